// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the register file and its read ports.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    // jal link target
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port.
// $0 reads zero; a live WB write to the same address is forwarded.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_word,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic is_zero;
    logic bypass;

    always_comb begin
        is_zero = (rd_addr == ADDR_W'(REG_ZERO));
        bypass  = wr_en && (wr_addr == rd_addr);
        rd_data = rd_word;
        if (is_zero) begin
            rd_data = '0;
        end else if (bypass) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// 32x32 MIPS register file: two bypassed combinational reads, one write.
// Sits across ID/WB so a WB write is visible to ID in the same cycle.
module register_file_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic              wr_live;

    // Reset blocks both the write and the forwarding path.
    assign wr_live = RegWrite && !Rst;

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WriteRegister != ADDR_W'(REG_ZERO))) begin
            regs_d[WriteRegister] = WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .rd_addr (ReadRegister1),
        .rd_word (regs_q[ReadRegister1]),
        .wr_en   (wr_live),
        .wr_addr (WriteRegister),
        .wr_data (WriteData),
        .rd_data (ReadData1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .rd_addr (ReadRegister2),
        .rd_word (regs_q[ReadRegister2]),
        .wr_en   (wr_live),
        .wr_addr (WriteRegister),
        .wr_data (WriteData),
        .rd_data (ReadData2)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w.
// Expected read values are queued when stimulus is applied, popped on sample.
module tb_register_file_2r1w;

    logic        Clk;
    logic        Rst;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    register_file_2r1w dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of inputs after the falling edge and let reads settle.
    task automatic apply(input logic rst, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge Clk);
        Rst           = rst;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            apply(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            sb.push_back('{$sformatf("reset_a%0d", a), 32'h0, 32'h0});
            e = sb.pop_front();
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        apply(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd9);
        sb.push_back('{"basic_wr", 32'h0, 32'h0});
        apply(1'b0, 1'b0, 5'd8, 32'h0, 5'd8, 5'd9);
        sb.push_back('{"basic_rd", 32'hDEADBEEF, 32'h0});
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            if (i == 0) begin
                // first entry belongs to the previous cycle; recheck path
                continue;
            end
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    task automatic test_zero();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, (i == 0), 5'd0, 32'h12345678, 5'd0, 5'd0);
            sb.push_back('{$sformatf("zero_%0d", i), 32'h0, 32'h0});
            e = sb.pop_front();
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic        we   [5];
        logic [31:0] wd   [5];
        logic [4:0]  r2   [5];
        we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        wd = '{32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h0};
        r2 = '{5'd5, 5'd8, 5'd5, 5'd5, 5'd8};
        sb.push_back('{"byp_first",  32'h11111111, 32'h11111111});
        sb.push_back('{"byp_stored", 32'h11111111, 32'hDEADBEEF});
        sb.push_back('{"byp_live",   32'h22222222, 32'h22222222});
        sb.push_back('{"byp_after",  32'h22222222, 32'h22222222});
        sb.push_back('{"byp_other",  32'h22222222, 32'hDEADBEEF});
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, we[i], 5'd5, wd[i], 5'd5, r2[i]);
            e = sb.pop_front();
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    task automatic test_gating();
        exp_t        e;
        logic        rst [5];
        logic        we  [5];
        logic [31:0] wd  [5];
        rst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        we  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        wd  = '{32'hFFFFFFFF, 32'h0, 32'h77, 32'h99, 32'h0};
        sb.push_back('{"gate_off",   32'h0,  32'hDEADBEEF});
        sb.push_back('{"gate_held",  32'h0,  32'hDEADBEEF});
        sb.push_back('{"gate_wr",    32'h77, 32'hDEADBEEF});
        sb.push_back('{"rst_nobyp",  32'h77, 32'hDEADBEEF});
        sb.push_back('{"rst_clear",  32'h0,  32'h0});
        for (int i = 0; i < 5; i++) begin
            apply(rst[i], we[i], 5'd31, wd[i], 5'd31, 5'd8);
            e = sb.pop_front();
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        we [4];
        logic [31:0] wd [4];
        logic [4:0]  r1 [4];
        we = '{1'b1, 1'b1, 1'b0, 1'b0};
        wd = '{32'hA, 32'hB, 32'h0, 32'h0};
        r1 = '{5'd1, 5'd1, 5'd5, 5'd8};
        sb.push_back('{"b2b_a",    32'h0, 32'hA});
        sb.push_back('{"b2b_b",    32'h0, 32'hB});
        sb.push_back('{"b2b_last", 32'h0, 32'hB});
        sb.push_back('{"b2b_keep", 32'h0, 32'hB});
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, we[i], 5'd31, wd[i], r1[i], 5'd31);
            e = sb.pop_front();
            n_chk++;
            if (ReadData1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s rd1 got %h exp %h", e.name, ReadData1, e.d1);
            end
            n_chk++;
            if (ReadData2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s rd2 got %h exp %h", e.name, ReadData2, e.d2);
            end
        end
    endtask

    initial begin
        Rst           = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_gating();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left got %0d exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
